// File: rtl/jam_gen_if.sv
// Bundle of the jam_gen request/lookup/result signals.
// The environment side (master) starts searches and answers cost lookups.
// The search engine side (slave) presents lookup indices and results.
interface jam_gen_if #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int MCW = 4
);
  localparam int IW = $clog2(N);
  localparam int SW = CW + $clog2(N);

  logic           Start;
  logic [IW:0]    Size;
  logic [IW-1:0]  W;
  logic [IW-1:0]  J;
  logic [CW-1:0]  Cost;
  logic [SW-1:0]  MinCost;
  logic [MCW-1:0] MatchCount;
  logic           Valid;
  logic           Busy;

  modport master (
    output Start, Size, Cost,
    input  W, J, MinCost, MatchCount, Valid, Busy
  );

  modport slave (
    input  Start, Size, Cost,
    output W, J, MinCost, MatchCount, Valid, Busy
  );
endinterface

// File: rtl/jam_gen.sv
// Exhaustive assignment-problem solver. Walks every permutation of the
// first n jobs in lexicographic order, sums cost[k][perm[k]] one worker per
// cycle, and tracks the minimum total plus how many permutations reach it.
module jam_gen #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int MCW = 4
) (
  input logic       CLK,
  input logic       RST,
  jam_gen_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam int SW = CW + $clog2(N);
  localparam int NW = IW + 1;

  typedef enum logic [2:0] {IDLE, SUM, CMP, NEXTP, DONE} state_t;

  state_t         r_state;
  logic [NW-1:0]  r_n;
  logic [IW-1:0]  r_perm [N];
  logic [IW-1:0]  r_w;
  logic [IW-1:0]  r_j;
  logic [SW-1:0]  r_sum;
  logic [SW-1:0]  r_min;
  logic [MCW-1:0] r_cnt;
  logic [SW-1:0]  r_min_out;
  logic [MCW-1:0] r_cnt_out;
  logic           r_valid;
  logic           r_busy;

  logic [NW-1:0]  w_size_n;
  logic           w_last_k;
  logic           w_has_piv;
  logic [IW-1:0]  w_piv;
  logic [IW-1:0]  w_swp;
  logic [IW-1:0]  w_nperm [N];
  logic [SW-1:0]  w_min_nxt;
  logic [MCW-1:0] w_cnt_nxt;

  assign bus.W          = r_w;
  assign bus.J          = r_j;
  assign bus.MinCost    = r_min_out;
  assign bus.MatchCount = r_cnt_out;
  assign bus.Valid      = r_valid;
  assign bus.Busy       = r_busy;

  // A zero or oversized request means "use the full problem size".
  assign w_size_n = (bus.Size == '0 || bus.Size > NW'(N)) ? NW'(N) : bus.Size;

  // The lookup for worker n-1 is the last term of the current sum.
  assign w_last_k = ({1'b0, r_w} == r_n - NW'(1));

  // Fold the finished sum into the running minimum and tie count.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_min_nxt = r_min;
    w_cnt_nxt = r_cnt;
    if (r_sum < r_min) begin
      w_min_nxt = r_sum;
      w_cnt_nxt = MCW'(1);
    end else if (r_sum == r_min) begin
      w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + MCW'(1);
    end
  end

  // Lexicographic successor of perm[0..n-1], computed in one pass:
  // pivot = rightmost i with perm[i] < perm[i+1]; swap it with the rightmost
  // larger element to its right; then reverse the suffix after the pivot.
  // No pivot means perm is the final descending permutation.
  always_comb begin
    w_has_piv = 1'b0;
    w_piv     = '0;
    w_swp     = '0;
    for (int p = 0; p < N - 1; p++) begin
      if (NW'(p + 1) < r_n && r_perm[p] < r_perm[p + 1]) begin
        w_has_piv = 1'b1;
        w_piv     = IW'(p);
      end
    end
    for (int q = 0; q < N; q++) begin
      if (IW'(q) > w_piv && NW'(q) < r_n && r_perm[q] > r_perm[w_piv]) begin
        w_swp = IW'(q);
      end
    end
    for (int p = 0; p < N; p++) begin
      w_nperm[p] = r_perm[p];
      if (IW'(p) == w_piv) begin
        w_nperm[p] = r_perm[w_swp];
      end else if (IW'(p) > w_piv && NW'(p) < r_n) begin
        // Mirror position inside the suffix, taking the swap into account.
        if (IW'(int'(r_n) + int'(w_piv) - p) == w_swp) begin
          w_nperm[p] = r_perm[w_piv];
        end else begin
          w_nperm[p] = r_perm[IW'(int'(r_n) + int'(w_piv) - p)];
        end
      end
    end
  end

  // Search controller: all state, lookup indices and results are registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_n       <= NW'(N);
      // NOTE: perm is a small register array that must read as identity
      // straight out of reset, so it is reset like any other flop.
      for (int p = 0; p < N; p++) r_perm[p] <= IW'(p);
      r_w       <= '0;
      r_j       <= '0;
      r_sum     <= '0;
      r_min     <= '1;
      r_cnt     <= '0;
      r_min_out <= '0;
      r_cnt_out <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every read in this block
      // sees the value from before the clock edge.
      unique case (r_state)
        IDLE, DONE: begin
          if (bus.Start) begin
            r_n       <= w_size_n;
            for (int p = 0; p < N; p++) r_perm[p] <= IW'(p);
            r_w       <= '0;
            r_j       <= '0;
            r_sum     <= '0;
            r_min     <= '1;
            r_cnt     <= '0;
            r_min_out <= '0;
            r_cnt_out <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= SUM;
          end
        end
        SUM: begin
          r_sum <= r_sum + SW'(bus.Cost);
          if (w_last_k) begin
            r_w     <= '0;
            r_j     <= '0;
            r_state <= CMP;
          end else begin
            r_w <= r_w + IW'(1);
            r_j <= r_perm[r_w + IW'(1)];
          end
        end
        CMP: begin
          r_min <= w_min_nxt;
          r_cnt <= w_cnt_nxt;
          if (w_has_piv) begin
            r_state <= NEXTP;
          end else begin
            r_min_out <= w_min_nxt;
            r_cnt_out <= w_cnt_nxt;
            r_valid   <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= DONE;
          end
        end
        NEXTP: begin
          r_perm  <= w_nperm;
          r_sum   <= '0;
          r_w     <= '0;
          r_j     <= w_nperm[0];
          r_state <= SUM;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/jam_gen.md
JAM_GEN -- requirements
Module: jam_gen

Interface
REQ-001 SHALL have parameter N, default 8, meaning the maximum number of workers and jobs (range 2..8).
REQ-002 SHALL have parameter CW, default 7, meaning the cost width in bits.
REQ-003 SHALL have parameter MCW, default 4, meaning the MatchCount width in bits.
REQ-004 SHALL use derived widths IW = clog2(N) and SW = CW+clog2(N); defaults give IW=3, SW=10.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all flops are rising-edge.
REQ-006 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port Start, input, 1 bit: single-cycle request to begin a search.
REQ-008 SHALL have port Size, input, IW+1 bits: active problem size n, sampled at Start.
REQ-009 SHALL have port W, output, IW bits: worker index of the cost lookup.
REQ-010 SHALL have port J, output, IW bits: job index of the cost lookup.
REQ-011 SHALL have port Cost, input, CW bits: cost[W][J], driven combinationally by the environment in the same cycle.
REQ-012 SHALL have port MinCost, output, SW bits: minimum total assignment cost.
REQ-013 SHALL have port MatchCount, output, MCW bits: number of assignments achieving MinCost.
REQ-014 SHALL have port Valid, output, 1 bit: result is ready.
REQ-015 SHALL have port Busy, output, 1 bit: a search is in progress.

Function
REQ-016 SHALL implement states IDLE, SUM, CMP, NEXTP and DONE.
REQ-017 SHALL, on Start=1 in IDLE or DONE, do all of the following in one cycle:
- latch n = Size;
- set perm[i] = i;
- clear MinCost, MatchCount and Valid;
- set internal min to all-ones;
- set Busy=1;
- go to SUM.
REQ-018 SHALL map Size=0 or Size>N to n=N.
REQ-019 SHALL ignore Start while Busy=1.
REQ-020 SHALL, in SUM, drive W=k and J=perm[k] for k=0..n-1, one k per cycle, and accumulate Cost into an SW-bit sum without overflow.
REQ-021 SHALL, in CMP (one cycle):
- if sum < min: load min with sum and set count to 1;
- if sum == min: increment count, saturating at 2^MCW-1;
- if sum > min: leave min and count unchanged.
REQ-022 SHALL, in NEXTP, generate the lexicographic successor of perm[0..n-1] in at most n+2 cycles, then return to SUM.
REQ-023 SHALL go from CMP to DONE, bypassing NEXTP, when perm is the final descending permutation; for n=1 this occurs after the first CMP.
REQ-024 SHALL, on entering DONE, copy min to MinCost and count to MatchCount, set Valid=1 and set Busy=0.
REQ-025 SHALL hold Valid, MinCost and MatchCount stable in DONE until the next accepted Start or reset.
REQ-026 SHALL complete a search within n!·(2n+3)+2 cycles of Start, which is at most 766082 cycles for n=8.
REQ-027 SHALL leave perm[n..N-1] untouched and never drive W or J at or above n while Busy=1.
REQ-028 SHALL drive W=0 and J=0 outside SUM.

Reset
REQ-029 SHALL, while RST=1, asynchronously force the following:
- state to IDLE;
- W, J, MinCost, MatchCount, Valid and Busy to 0;
- perm to identity;
- internal min to all-ones.
REQ-030 SHALL abort an in-progress search on RST and produce no Valid until a new Start after RST deasserts.
REQ-031 SHALL accept Start no earlier than the first rising edge after RST deasserts.

Verification
REQ-032 SHALL pass: N=8, Size=1, cost[0][0]=5 -> Valid with MinCost=5, MatchCount=1.
REQ-033 SHALL pass: Size=2, cost=[[1,9],[9,1]] -> MinCost=2, MatchCount=1.
REQ-034 SHALL pass: Size=3, all costs=1 -> MinCost=3, MatchCount=6.
REQ-035 SHALL pass: Size=8, all costs=0 -> MinCost=0, MatchCount=15 (saturated, 40320 ties), Valid within 766082 cycles.
REQ-036 SHALL pass: Size=8, cost[w][j]=127 except cost[w][7-w]=0 -> MinCost=0, MatchCount=1; with all costs=127 -> MinCost=1016, with no SW overflow.
REQ-037 SHALL pass both of the following:
- RST pulsed mid-search -> all outputs 0 at once, and a later Start with Size=2 gives the correct result;
- Start pulsed while Busy -> no restart, and the original result is unchanged.
